// File: rtl/arb_mux_reg.sv
// ---------------------------------------------------------------------------
// arb_mux_reg
//
// Flow-controlled N:1 merge point with one output register stage. Each input
// has a valid/ready handshake; the single output has a registered valid and
// data plus a consumer ready. The winning input is picked either explicitly
// (mode 0, by sel) or by a round-robin arbiter (mode 1) that starts its scan
// at an internal pointer and moves past the last winner.
//
// Parameters:
//   WIDTH  data width of each input and of the output
//   N      number of inputs (2..16)
//   SW     width of sel, derived from N (not overridable)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    N*WIDTH packed inputs, input i at [i*WIDTH +: WIDTH]
//   in_valid   per-input valid
//   in_ready   per-input ready, combinational, at most one bit high
//   sel        input index used in mode 0
//   mode       0 = explicit select, 1 = round-robin
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  consumer ready
// ---------------------------------------------------------------------------
module arb_mux_reg #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SW-1:0]    ptr;
    logic [SW-1:0]    gnt;
    logic             gnt_v;
    logic             load_en;
    logic             accept;
    logic [WIDTH-1:0] gnt_data;
    int               idx;

    // The register can take a new entry when it is empty or being drained.
    assign load_en = !out_valid || out_ready;

    // Grant selection. In mode 0 an out-of-range sel simply never matches an
    // input, so nothing is granted. In mode 1 the rotated scan runs from the
    // farthest offset down to the pointer, so the entry nearest the pointer
    // is the one left standing.
    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        idx   = 0;
        if (!mode) begin
            gnt = sel;
            for (int i = 0; i < N; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    gnt_v = 1'b1;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (in_valid[idx]) begin
                    gnt = SW'(idx);
                end
            end
            gnt_v = |in_valid;
        end
    end

    // Ready goes to the granted input only, and the data mux follows the
    // grant with an explicit loop so an out-of-range index never slices.
    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(gnt) == i) begin
                in_ready[i] = load_en && gnt_v;
                gnt_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // gnt_v already implies the granted input is valid.
    assign accept = load_en && gnt_v;

    // Output register and round-robin pointer. Refill takes priority over
    // drain, which is what gives one transfer per cycle under out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_data  <= gnt_data;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= (int'(gnt) == N - 1) ? '0 : gnt + SW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_arb_mux_reg
//
// Drives two instances of arb_mux_reg from the same stimulus: a 4-input one
// and a 3-input one (the latter exercises an out-of-range sel). A
// behavioural model tracks, per instance, whether the output slot is full,
// what it holds and where round-robin scanning starts, and predicts ready
// and output values from the arbitration rules directly.
// ---------------------------------------------------------------------------
module tb_arb_mux_reg;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             mode;
    logic [1:0]       sel;
    logic [3:0]       in_valid;
    logic [31:0]      dw [4];
    logic [127:0]     in_data;
    logic             out_ready;

    logic [3:0]       in_ready_a;
    logic [31:0]      out_data_a;
    logic             out_valid_a;
    logic [2:0]       in_ready_b;
    logic [31:0]      out_data_b;
    logic             out_valid_b;

    int checks;
    int errors;

    // Model state, index 0 = 4-input instance, index 1 = 3-input instance.
    int          nn [2];
    logic        m_valid [2];
    logic [31:0] m_data [2];
    int          m_ptr [2];
    logic        m_init;

    assign in_data = {dw[3], dw[2], dw[1], dw[0]};

    arb_mux_reg #(.WIDTH(WIDTH), .N(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready)
    );

    arb_mux_reg #(.WIDTH(WIDTH), .N(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data[95:0]),
        .in_valid  (in_valid[2:0]),
        .in_ready  (in_ready_b),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Winner under the arbitration rules, or -1 when nothing is granted.
    function automatic int modelGrant(input int n, input logic md, input logic [1:0] s,
                                      input logic [3:0] v, input int p);
        if (!md) begin
            if (int'(s) < n && v[s]) return int'(s);
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares combinational ready of both instances against the model.
    task automatic checkReady(input string tag);
        int   g;
        logic load;
        logic [3:0] exp;
        for (int u = 0; u < 2; u++) begin
            g    = modelGrant(nn[u], mode, sel, in_valid, m_ptr[u]);
            load = !m_valid[u] || out_ready;
            exp  = (load && g >= 0) ? 4'(1 << g) : 4'b0;
            if (u == 0) chk({tag, "_rdy_a"}, {28'b0, in_ready_a}, {28'b0, exp});
            else        chk({tag, "_rdy_b"}, {29'b0, in_ready_b}, {28'b0, exp});
        end
    endtask

    // Compares the registered outputs of both instances against the model.
    task automatic checkOutput(input string tag);
        chk({tag, "_vld_a"}, {31'b0, out_valid_a}, {31'b0, m_valid[0]});
        chk({tag, "_dat_a"}, out_data_a, m_data[0]);
        chk({tag, "_vld_b"}, {31'b0, out_valid_b}, {31'b0, m_valid[1]});
        chk({tag, "_dat_b"}, out_data_b, m_data[1]);
    endtask

    // One clock cycle: drive, check ready, clock, advance model, check output.
    task automatic applyStimulus(input string tag, input logic r, input logic md,
                                 input logic [1:0] s, input logic [3:0] v, input logic ordy);
        int   g;
        logic load;
        rst       = r;
        mode      = md;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        #1;
        if (m_init) checkReady(tag);
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            g    = modelGrant(nn[u], md, s, v, m_ptr[u]);
            load = !m_valid[u] || ordy;
            if (r) begin
                m_valid[u] = 1'b0;
                m_data[u]  = '0;
                m_ptr[u]   = 0;
            end else if (load && g >= 0) begin
                m_valid[u] = 1'b1;
                m_data[u]  = dw[g];
                if (md) m_ptr[u] = (g + 1) % nn[u];
            end else if (ordy) begin
                m_valid[u] = 1'b0;
            end
        end
        if (r) m_init = 1'b1;
        #1;
        if (m_init) checkOutput(tag);
        @(negedge clk);
    endtask

    logic [31:0] rr_seq [6];

    initial begin
        checks  = 0;
        errors  = 0;
        nn[0]   = 4;
        nn[1]   = 3;
        m_init  = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = 1'b0;
            m_data[u]  = '0;
            m_ptr[u]   = 0;
        end
        dw[0] = 32'd10;
        dw[1] = 32'd20;
        dw[2] = 32'd30;
        dw[3] = 32'd40;
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;

        // Reset held two cycles with every input valid.
        applyStimulus("reset0", 1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
        applyStimulus("reset1", 1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
        chk("reset_vld", {31'b0, out_valid_a}, 32'd0);
        chk("reset_dat", out_data_a, 32'd0);

        // Round-robin with wrap: first grant after reset is input 0.
        rr_seq[0] = 32'd10; rr_seq[1] = 32'd20; rr_seq[2] = 32'd30;
        rr_seq[3] = 32'd40; rr_seq[4] = 32'd10; rr_seq[5] = 32'd20;
        for (int c = 0; c < 6; c++) begin
            applyStimulus("rr", 1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
            chk("rr_seq", out_data_a, rr_seq[c]);
            chk("rr_vld", {31'b0, out_valid_a}, 32'd1);
        end

        // Explicit select 2 then 1.
        applyStimulus("sel2", 1'b0, 1'b0, 2'd2, 4'hF, 1'b1);
        chk("sel2_dat", out_data_a, 32'd30);
        applyStimulus("sel1", 1'b0, 1'b0, 2'd1, 4'hF, 1'b1);
        chk("sel1_dat", out_data_a, 32'd20);

        // Round-robin skip over idle inputs from a fresh pointer.
        applyStimulus("skip_rst", 1'b1, 1'b1, 2'd0, 4'b1010, 1'b1);
        applyStimulus("skip0", 1'b0, 1'b1, 2'd0, 4'b1010, 1'b1);
        chk("skip0_dat", out_data_a, 32'd20);
        applyStimulus("skip1", 1'b0, 1'b1, 2'd0, 4'b1010, 1'b1);
        chk("skip1_dat", out_data_a, 32'd40);
        applyStimulus("skip2", 1'b0, 1'b1, 2'd0, 4'b1010, 1'b1);
        chk("skip2_dat", out_data_a, 32'd20);

        // Backpressure: load input 0, stall three cycles, then release.
        applyStimulus("bp_load", 1'b0, 1'b0, 2'd0, 4'hF, 1'b1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus("bp_stall", 1'b0, 1'b0, 2'd0, 4'hF, 1'b0);
            chk("bp_hold", out_data_a, 32'd10);
        end
        applyStimulus("bp_release", 1'b0, 1'b0, 2'd1, 4'hF, 1'b1);
        chk("bp_refill", out_data_a, 32'd20);
        chk("bp_refill_vld", {31'b0, out_valid_a}, 32'd1);

        // Invalid select on the 3-input instance drains and stays empty.
        applyStimulus("badsel0", 1'b0, 1'b0, 2'd3, 4'hF, 1'b1);
        applyStimulus("badsel1", 1'b0, 1'b0, 2'd3, 4'hF, 1'b1);
        chk("badsel_vld_b", {31'b0, out_valid_b}, 32'd0);

        // Randomised traffic including occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < 4; w++) dw[w] = $urandom;
            applyStimulus("rand", ($urandom_range(0, 31) == 0), 1'($urandom),
                          2'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
